nco_ctrl: RTL and testbench
===========================

NCO_CTRL -- requirements
Module: nco_ctrl

Interface
REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 10: sine table address width, matching the sine generator's i_phase_count.
REQ-003 SHALL have parameter WIDTH, default 24: sample width.
REQ-004 SHALL have parameter CNT_W, default 16: burst length counter width.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports i_cfg_valid (in, 1) and o_cfg_ready (out, 1): configuration handshake.
REQ-008 SHALL have ports i_cfg_ftw (in, PHASE_W), i_cfg_pofs (in, ADDR_W) and i_cfg_len (in, CNT_W): frequency word, phase offset, and sample count (0 = continuous).
REQ-009 SHALL have ports i_start (in, 1) and i_stop (in, 1): single-cycle burst control pulses.
REQ-010 SHALL have port o_phase_count, out, ADDR_W: registered table address driven to the sine generator.
REQ-011 SHALL have port i_sine_data, in, WIDTH: sine generator output, valid one cycle after o_phase_count changes.
REQ-012 SHALL have ports o_sample (out, WIDTH), o_sample_valid (out, 1) and i_sample_ready (in, 1): output stream.
REQ-013 SHALL have ports o_busy (out, 1) and o_done (out, 1): status; o_done is a single-cycle pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-015 SHALL assert o_cfg_ready only in IDLE; a cfg handshake latches ftw, pofs and len.
REQ-016 SHALL treat i_start in IDLE (cycle T) as follows: accumulator cleared, remaining count loaded from len, RUN entered at T+1.
REQ-017 SHALL ignore i_start outside IDLE.
REQ-018 SHALL issue at most one address per cycle in RUN, only when (output FIFO occupancy + in-flight count) < 4.
REQ-019 SHALL, on each issue, make o_phase_count = upper ADDR_W bits of (acc + (pofs << (PHASE_W-ADDR_W))) and then advance acc += ftw modulo 2^PHASE_W, with silent wrap.
REQ-020 SHALL track two in-flight stages: address register, then sine ROM; i_sine_data SHALL be captured into a 4-entry output FIFO exactly 2 cycles after the issue cycle.
REQ-021 SHALL present the FIFO head on o_sample with o_sample_valid, transfer on valid&&ready, keep o_sample stable while stalled, and drop no samples.
REQ-022 SHALL, once the first sample is issued at T+1 and i_sample_ready is held high, give first o_sample_valid at T+3 and one sample per cycle thereafter.
REQ-023 SHALL decrement the remaining count per issue when len != 0; when the last sample issues, go RUN->DRAIN.
REQ-024 SHALL, on i_stop in RUN, stop issuing the next cycle and enter DRAIN; i_stop in IDLE/DRAIN is ignored; i_stop and a last-issue in the same cycle behave as a single DRAIN entry.
REQ-025 SHALL leave DRAIN for IDLE when in-flight = 0 and the FIFO is empty, pulsing o_done for one cycle on that transition.
REQ-026 SHALL hold o_busy = 1 in RUN and DRAIN.
REQ-027 SHALL hold o_phase_count at its last value while not issuing.

Reset
REQ-028 SHALL, on i_rst_n low, immediately set state IDLE, acc/count/FIFO/in-flight to 0, and o_phase_count, o_sample, o_sample_valid, o_busy and o_done to 0, with o_cfg_ready = 1 after release; latched config cleared to 0.
REQ-029 SHALL discard in-flight and FIFO samples on reset mid-burst, and SHALL NOT produce o_done.

Configuration
REQ-030 SHALL, with macro NCO_CHIRP_EN defined, add input i_cfg_fstep (PHASE_W), latched with the cfg handshake, and add fstep to the working ftw after each issue (mod 2^PHASE_W); the working ftw reloads from the latched ftw on i_start.
REQ-031 SHALL, without NCO_CHIRP_EN, omit i_cfg_fstep and keep ftw constant for the burst.

Verification
REQ-032 SHALL cover: ftw=0x0040_0000, pofs=0, len=8, ready=1 -> o_phase_count 0..7, 8 samples at T+3..T+10, o_done once, then IDLE.
REQ-033 SHALL cover: ftw=0x8000_0000, pofs=0x100, len=4 -> addresses 0x100,0x300,0x100,0x300 (wrap).
REQ-034 SHALL cover: len=0, ready toggling 1-0-0-1 for 40 cycles, then i_stop -> no sample lost or duplicated, FIFO never exceeds 4, then DRAIN, then o_done.
REQ-035 SHALL cover: i_rst_n low at mid-burst sample 3 -> all outputs 0 that cycle, no o_done, and a new cfg accepted after release.
REQ-036 SHALL cover, with NCO_CHIRP_EN: ftw=0x0040_0000, fstep=0x0040_0000, len=4 -> addresses 0,1,3,6.

Source files
------------

// File: rtl/nco_ctrl.sv
// Burst controller for a table-based NCO: phase accumulation, sine-table addressing and a 4-deep output FIFO.
// Optional macro NCO_CHIRP_EN adds a per-issue frequency step (linear chirp).
module nco_ctrl #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [PHASE_W-1:0] i_cfg_ftw,
  input  logic [ADDR_W-1:0]  i_cfg_pofs,
  input  logic [CNT_W-1:0]   i_cfg_len,
`ifdef NCO_CHIRP_EN
  input  logic [PHASE_W-1:0] i_cfg_fstep,
`endif
  input  logic               i_start,
  input  logic               i_stop,
  output logic [ADDR_W-1:0]  o_phase_count,
  input  logic [WIDTH-1:0]   i_sine_data,
  output logic [WIDTH-1:0]   o_sample,
  output logic               o_sample_valid,
  input  logic               i_sample_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam int unsigned SHIFT   = PHASE_W - ADDR_W;

  logic [1:0]         state_q, state_d;
  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [ADDR_W-1:0]  pofs_q, pofs_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  phase_q, phase_d;
  logic               v1_q, v2_q;
  logic               done_q, done_d;
`ifdef NCO_CHIRP_EN
  logic [PHASE_W-1:0] fstep_q, fstep_d;
  logic [PHASE_W-1:0] wftw_q, wftw_d;
`endif

  logic [WIDTH-1:0]   mem_q [4];
  logic [1:0]         wr_ptr_q, rd_ptr_q;
  logic [2:0]         count_q, count_d;

  logic               start, run_iss, iss, credit, have_cnt, push, pop;
  logic [PHASE_W-1:0] acc_base, step, pofs_ext;

  assign pofs_ext = {pofs_q, {SHIFT{1'b0}}};
  assign start    = (state_q == ST_IDLE) && i_start;
  // Credit counts samples already in the FIFO plus those still travelling through address reg and ROM.
  assign credit   = ({1'b0, count_q} + {3'b000, v1_q} + {3'b000, v2_q}) < 4'd4;
  assign have_cnt = (len_q == '0) || (cnt_q != '0);
  assign run_iss  = (state_q == ST_RUN) && have_cnt && credit;
  // The first address goes out on the start edge so the first sample lands two cycles later.
  assign iss      = start || run_iss;
  assign acc_base = start ? '0 : acc_q;
`ifdef NCO_CHIRP_EN
  assign step     = start ? ftw_q : wftw_q;
`else
  assign step     = ftw_q;
`endif
  assign push     = v2_q;
  assign pop      = o_sample_valid && i_sample_ready;

  always_comb begin
    state_d = state_q;
    ftw_d   = ftw_q;
    pofs_d  = pofs_q;
    len_d   = len_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    count_d = count_q + {2'b00, push} - {2'b00, pop};
`ifdef NCO_CHIRP_EN
    fstep_d = fstep_q;
    wftw_d  = wftw_q;
`endif

    if (i_cfg_valid && (state_q == ST_IDLE)) begin
      ftw_d  = i_cfg_ftw;
      pofs_d = i_cfg_pofs;
      len_d  = i_cfg_len;
`ifdef NCO_CHIRP_EN
      fstep_d = i_cfg_fstep;
`endif
    end

    if (iss) begin
      phase_d = ADDR_W'((acc_base + pofs_ext) >> SHIFT);
      acc_d   = acc_base + step;
`ifdef NCO_CHIRP_EN
      wftw_d  = step + fstep_q;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          cnt_d   = (len_q == '0) ? '0 : len_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (run_iss && (len_q != '0)) cnt_d = cnt_q - 1'b1;
        if (i_stop || !have_cnt || (run_iss && (len_q != '0) && (cnt_q == CNT_W'(1))))
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!v1_q && !v2_q && (count_q == '0)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ftw_q   <= '0;
      pofs_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
`ifdef NCO_CHIRP_EN
      fstep_q <= '0;
      wftw_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ftw_q   <= ftw_d;
      pofs_q  <= pofs_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      v1_q    <= iss;
      v2_q    <= v1_q;
      done_q  <= done_d;
      count_q <= count_d;
`ifdef NCO_CHIRP_EN
      fstep_q <= fstep_d;
      wftw_q  <= wftw_d;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= i_sine_data;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  assign o_cfg_ready    = (state_q == ST_IDLE);
  assign o_phase_count  = phase_q;
  assign o_sample       = mem_q[rd_ptr_q];
  assign o_sample_valid = (count_q != '0);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = done_q;

endmodule

// File: tb/tb_nco_ctrl.sv
// Directed bench for nco_ctrl: registered ROM model, expected-sample scoreboard queue, immediate-assertion checks.
module tb_nco_ctrl;
  localparam int PW = 32;
  localparam int AW = 10;
  localparam int SW = 24;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [PW-1:0] cfg_ftw = '0;
  logic [AW-1:0] cfg_pofs = '0;
  logic [CW-1:0] cfg_len = '0;
`ifdef NCO_CHIRP_EN
  logic [PW-1:0] cfg_fstep = '0;
`endif
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] phase;
  logic [SW-1:0] rom_q = '0;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;
  int popped = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [SW-1:0] prev_sample = '0;
  logic [SW-1:0] exp_q[$];

  always #5 clk = ~clk;

  nco_ctrl #(.PHASE_W(PW), .ADDR_W(AW), .WIDTH(SW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_ftw(cfg_ftw), .i_cfg_pofs(cfg_pofs), .i_cfg_len(cfg_len),
`ifdef NCO_CHIRP_EN
    .i_cfg_fstep(cfg_fstep),
`endif
    .i_start(start), .i_stop(stop),
    .o_phase_count(phase), .i_sine_data(rom_q),
    .o_sample(sample), .o_sample_valid(sample_valid), .i_sample_ready(sample_ready),
    .o_busy(busy), .o_done(done)
  );

  function automatic logic [SW-1:0] sine_f(input logic [AW-1:0] a);
    return {4'h5, a, ~a};
  endfunction

  always @(posedge clk) rom_q <= sine_f(phase);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_hold", 64'(sample), 64'(prev_sample));
        chk("stall_valid", 64'(sample_valid), 64'd1);
      end
      if (sample_valid && sample_ready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL sb_extra observed=%0h expected=none", sample);
        end
        if (exp_q.size() != 0) chk("sample", 64'(sample), 64'(exp_q.pop_front()));
        popped++;
      end
      prev_stall  = sample_valid && !sample_ready;
      prev_sample = sample;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_burst(input logic [PW-1:0] ftw, input logic [AW-1:0] pofs,
                            input logic [PW-1:0] fstep, input int n);
    logic [PW-1:0] acc, w, ph;
    acc = '0;
    w   = ftw;
    for (int i = 0; i < n; i++) begin
      ph = acc + {pofs, 22'b0};
      exp_q.push_back(sine_f(ph[31:22]));
      acc = acc + w;
      w   = w + fstep;
    end
  endtask

  task automatic cfg(input logic [PW-1:0] ftw, input logic [AW-1:0] pofs,
                     input logic [CW-1:0] len, input logic [PW-1:0] fstep);
    cfg_valid = 1'b1;
    cfg_ftw   = ftw;
    cfg_pofs  = pofs;
    cfg_len   = len;
`ifdef NCO_CHIRP_EN
    cfg_fstep = fstep;
`else
    if (fstep != '0) $display("note: fstep ignored in this build");
`endif
    @(negedge clk);
    chk("cfg_ready", 64'(cfg_ready), 64'd1);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(busy), 64'd0);
    cyc();
  endtask

  task automatic check_phases(input string tag, input logic [AW-1:0] exp_a[$]);
    for (int k = 0; k < exp_a.size(); k++) begin
      @(negedge clk);
      chk(tag, 64'(phase), 64'(exp_a[k]));
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int p0;
    logic [AW-1:0] ph_list[$];
    bit pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    #1 rst_n = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_sample", 64'(sample), 64'd0);
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // basic burst: ftw = one address step, len 8, ready held high
    sample_ready = 1'b1;
    mon_en = 1'b1;
    p0 = popped;
    d0 = done_cnt;
    push_burst(32'h0040_0000, 10'h000, 32'h0, 8);
    cfg(32'h0040_0000, 10'h000, 16'd8, 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("b1_phase", 64'(phase), 64'((k <= 8) ? k - 1 : 7));
      chk("b1_valid", 64'(sample_valid), 64'(k >= 3));
      chk("b1_busy", 64'(busy), 64'd1);
      if (k == 1) chk("b1_cfg_ready_run", 64'(cfg_ready), 64'd0);
      cyc();
    end
    wait_idle("b1_idle", 20);
    repeat (3) cyc();
    chk("b1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("b1_count", 64'(popped - p0), 64'd8);
    chk("b1_sb_empty", 64'(exp_q.size()), 64'd0);

    // phase wrap with offset
    d0 = done_cnt;
    push_burst(32'h8000_0000, 10'h100, 32'h0, 4);
    cfg(32'h8000_0000, 10'h100, 16'd4, 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    ph_list = '{10'h100, 10'h300, 10'h100, 10'h300};
    check_phases("b2_phase", ph_list);
    wait_idle("b2_idle", 20);
    repeat (2) cyc();
    chk("b2_done_once", 64'(done_cnt - d0), 64'd1);
    chk("b2_sb_empty", 64'(exp_q.size()), 64'd0);

    // continuous run with back-pressure, a stray start, then stop
    d0 = done_cnt;
    p0 = popped;
    push_burst(32'h0123_4567, 10'h005, 32'h0, 120);
    cfg(32'h0123_4567, 10'h005, 16'd0, 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample_ready = pat[i % 4];
      start = (i == 10);
      cyc();
    end
    start = 1'b0;
    stop = 1'b1;
    sample_ready = pat[0];
    cyc();
    stop = 1'b0;
    @(negedge clk);
    chk("b3_busy_drain", 64'(busy), 64'd1);
    chk("b3_cfg_ready_drain", 64'(cfg_ready), 64'd0);
    for (int i = 0; i < 40 && busy; i++) begin
      sample_ready = pat[(i + 1) % 4];
      cyc();
      @(negedge clk);
    end
    chk("b3_idle", 64'(busy), 64'd0);
    sample_ready = 1'b1;
    cyc();
    repeat (2) cyc();
    chk("b3_done_once", 64'(done_cnt - d0), 64'd1);
    chk("b3_throughput", 64'((popped - p0) >= 15), 64'd1);
    chk("b3_no_valid", 64'(sample_valid), 64'd0);
    exp_q.delete();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    @(negedge clk);
    chk("stop_idle_ignored", 64'(busy), 64'd0);
    cyc();

    // reset in the middle of a burst
    d0 = done_cnt;
    push_burst(32'h0040_0000, 10'h000, 32'h0, 16);
    cfg(32'h0040_0000, 10'h000, 16'd16, 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_phase", 64'(phase), 64'd0);
    chk("mr_sample", 64'(sample), 64'd0);
    chk("mr_valid", 64'(sample_valid), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    cyc();
    rst_n = 1'b1;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("mr_cfg_ready", 64'(cfg_ready), 64'd1);
      cyc();
    end
    chk("mr_no_done", 64'(done_cnt - d0), 64'd0);
    mon_en = 1'b1;
    push_burst(32'h0040_0000, 10'h3FF, 32'h0, 2);
    cfg(32'h0040_0000, 10'h3FF, 16'd2, 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    ph_list = '{10'h3FF, 10'h000};
    check_phases("mr_phase_after", ph_list);
    wait_idle("mr_idle", 20);
    repeat (2) cyc();
    chk("mr_done_after", 64'(done_cnt - d0), 64'd1);
    chk("mr_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef NCO_CHIRP_EN
    d0 = done_cnt;
    push_burst(32'h0040_0000, 10'h000, 32'h0040_0000, 4);
    cfg(32'h0040_0000, 10'h000, 16'd4, 32'h0040_0000);
    start = 1'b1;
    cyc();
    start = 1'b0;
    ph_list = '{10'd0, 10'd1, 10'd3, 10'd6};
    check_phases("chirp_phase", ph_list);
    wait_idle("chirp_idle", 20);
    repeat (2) cyc();
    chk("chirp_done", 64'(done_cnt - d0), 64'd1);
    chk("chirp_sb_empty", 64'(exp_q.size()), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
